// File: rtl/mcu_control_fsm.sv
// mcu_control_fsm: multicycle RV32I control FSM; ir/intr/mem_ready in, PC/regfile/memory enables, imm_sel, trap status and debug state out
module mcu_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        intr,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_rden1,
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic [2:0]  imm_sel,
  output logic        int_taken,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, OPIMM = 7'b0010011, OP = 7'b0110011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;
  state_t st, nx, eoi;
  logic [6:0] op_q;
  logic [7:0] cnt;
  logic [1:0] cause_nx;
  logic intr_q, intr_pending, intr_rise, legal, is_alu, is_br, is_ld, is_st, timeout, unused_ir;
  assign unused_ir = ^ir[31:7];
  assign legal = ir[6:0] inside {LUI, AUIPC, OPIMM, OP, JAL, JALR, BRANCH, LOAD, STORE};
  assign is_alu = op_q inside {LUI, AUIPC, OPIMM, OP, JAL, JALR};
  assign is_br = op_q == BRANCH;
  assign is_ld = op_q == LOAD;
  assign is_st = op_q == STORE;
  assign intr_rise = intr & ~intr_q;
  assign eoi = intr_pending ? TRAP : FETCH;
  assign timeout = cnt == 8'(MEM_TIMEOUT - 1);
  assign state = st;
  assign imm_sel = !(st inside {EXEC, MEM, WB}) ? 3'd0 :
                   is_st ? 3'd1 :
                   is_br ? 3'd2 :
                   (op_q inside {LUI, AUIPC}) ? 3'd3 :
                   op_q == JAL ? 3'd4 : 3'd0;
  always_comb begin
    nx = FETCH;
    cause_nx = 2'd0;
    ir_load = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2 = 1'b0;
    int_taken = 1'b0;
    case (st)
      FETCH: begin
        mem_rden1 = 1'b1;
        nx = DECODE;
      end
      DECODE: begin
        ir_load = 1'b1;
        nx = legal ? EXEC : TRAP;
        cause_nx = 2'd1;
      end
      EXEC: begin
        mem_rden2 = is_ld;
        mem_we2 = is_st;
        pc_write = is_alu | is_br;
        reg_write = is_alu;
        nx = (is_ld | is_st) ? MEM : eoi;
      end
      MEM: begin
        mem_rden2 = is_ld;
        mem_we2 = is_st;
        pc_write = is_st & mem_ready;
        nx = mem_ready ? (is_ld ? WB : eoi) : timeout ? TRAP : MEM;
        cause_nx = (!mem_ready && timeout) ? 2'd2 : 2'd0;
      end
      WB: begin
        reg_write = 1'b1;
        pc_write = 1'b1;
        nx = eoi;
      end
      TRAP: begin
        int_taken = 1'b1;
        pc_write = 1'b1;
        nx = FETCH;
      end
      default: nx = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= FETCH;
      op_q <= '0;
      cnt <= '0;
      intr_q <= 1'b0;
      intr_pending <= 1'b0;
      trap_cause <= 2'd0;
    end else begin
      st <= nx;
      intr_q <= intr;
      intr_pending <= intr_rise | (intr_pending & (nx != TRAP));
      cnt <= (st == MEM && nx == MEM) ? cnt + 8'd1 : 8'd0;
      if (st == DECODE) op_q <= ir[6:0];
      if (nx == TRAP) trap_cause <= cause_nx;
    end
  end
endmodule

// File: tb/tb_mcu_control_fsm.sv
// tb_mcu_control_fsm: directed bench with an instruction-level expected-cycle model for mcu_control_fsm
module tb_mcu_control_fsm;
  localparam int TO = 15;
  localparam logic [31:0] ADDI = 32'h00500093, ADD = 32'h002081B3, LW = 32'h0000A103, SW = 32'h0020A023, BEQ = 32'h00208463;
  localparam int NEVER = 1 << 30;
  logic clk = 1'b0, rst = 1'b1, intr = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic ir_load, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, int_taken;
  logic [2:0] imm_sel, state;
  logic [1:0] trap_cause;
  mcu_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ir(ir), .intr(intr), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_write(pc_write), .reg_write(reg_write),
    .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .mem_we2(mem_we2),
    .imm_sel(imm_sel), .int_taken(int_taken), .trap_cause(trap_cause), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] st;
    logic irl, pcw, rgw, r1, r2, we, it;
    logic [2:0] imm;
    logic [1:0] tc;
  } rec_t;
  rec_t exp_q[$];
  rec_t ce, ca;
  int errors = 0, checks = 0;
  int n_cyc = 0, ion = NEVER, ioff = NEVER, ion2 = NEVER, ioff2 = NEVER;
  int n_it = 0, n_rw = 0, n_r2m = 0;
  logic m_pend = 1'b0, iprev = 1'b0;
  logic [1:0] m_cause = 2'd0;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic rec_t mk(input int s, input int irl, input int pcw, input int rgw, input int r1,
                              input int r2, input int we, input int it, input int imm);
    mk = {3'(s), irl != 0, pcw != 0, rgw != 0, r1 != 0, r2 != 0, we != 0, it != 0, 3'(imm), 2'd0};
  endfunction
  // One clock cycle: drive inputs, queue the expected outputs, then advance the interrupt/trap model.
  task automatic cyc(input rec_t r, input int rdy, input int ent, input int cause);
    logic rise;
    intr = (n_cyc >= ion && n_cyc < ioff) || (n_cyc >= ion2 && n_cyc < ioff2);
    mem_ready = rdy != 0;
    r.tc = m_cause;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    rise = intr & ~iprev;
    iprev = intr;
    m_pend = rise | (m_pend & (ent == 0));
    if (ent != 0) m_cause = 2'(cause);
    n_cyc++;
  endtask
  // One instruction; w = mem_ready wait cycles (w >= TO means mem_ready never comes); n = cycles used incl. trap.
  task automatic run(input logic [31:0] code, input int w, output int n);
    logic [6:0] op;
    logic ld, sw, br, alu, ill;
    int imm, tr;
    op = code[6:0];
    ld = op == 7'h03;
    sw = op == 7'h23;
    br = op == 7'h63;
    alu = op inside {7'h37, 7'h17, 7'h13, 7'h33, 7'h6f, 7'h67};
    ill = !(ld || sw || br || alu);
    imm = sw ? 1 : br ? 2 : (op == 7'h37 || op == 7'h17) ? 3 : op == 7'h6f ? 4 : 0;
    tr = 0;
    n = 0;
    ir = code;
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0); n++;
    cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 0, int'(ill), 1); n++;
    if (ill) tr = 1;
    else if (alu || br) begin
      tr = int'(m_pend);
      cyc(mk(2, 0, 1, int'(alu), 0, 0, 0, 0, imm), 0, tr, 0); n++;
    end else begin
      cyc(mk(2, 0, 0, 0, 0, int'(ld), int'(sw), 0, imm), 0, 0, 0); n++;
      if (w >= TO) begin
        for (int k = 0; k < TO; k++) begin
          cyc(mk(3, 0, 0, 0, 0, int'(ld), int'(sw), 0, imm), 0, int'(k == TO - 1), 2); n++;
        end
        tr = 1;
      end else begin
        for (int k = 0; k < w; k++) begin
          cyc(mk(3, 0, 0, 0, 0, int'(ld), int'(sw), 0, imm), 0, 0, 0); n++;
        end
        tr = int'(sw & m_pend);
        cyc(mk(3, 0, int'(sw), 0, 0, int'(ld), int'(sw), 0, imm), 1, tr, 0); n++;
        if (ld) begin
          tr = int'(m_pend);
          cyc(mk(4, 0, 1, 1, 0, 0, 0, 0, imm), 0, tr, 0); n++;
        end
      end
    end
    if (tr != 0) begin
      cyc(mk(5, 0, 1, 0, 0, 0, 0, 1, 0), 0, 0, 0); n++;
    end
    mem_ready = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (int_taken) n_it++;
      if (reg_write) n_rw++;
      if (mem_rden2 && state == 3'd3) n_r2m++;
    end
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      ca = {state, ir_load, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, int_taken, imm_sel, trap_cause};
      checks++;
      if (ca !== ce) begin
        errors++;
        $display("FAIL cycle %0d outputs {st,irl,pcw,rgw,rd1,rd2,we2,it,imm,tc}: got %b expected %b", n_cyc, ca, ce);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, r0, w0, i0, n0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_rden1", int'(mem_rden1), 1);
    check("reset_enables", int'({ir_load, pc_write, reg_write, mem_rden2, mem_we2, int_taken}), 0);
    check("reset_imm_sel", int'(imm_sel), 0);
    check("reset_trap_cause", int'(trap_cause), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(ADDI, 0, n);
    check("addi_cycles", n, 3);
    r0 = n_r2m;
    w0 = n_rw;
    run(LW, 2, n);
    check("lw_cycles", n, 7);
    check("lw_rden2_mem_cycles", n_r2m - r0, 3);
    check("lw_regwrite_cycles", n_rw - w0, 1);
    run(SW, 0, n);
    check("sw_cycles", n, 4);
    w0 = n_rw;
    i0 = n_it;
    run(LW, TO, n);
    check("lw_timeout_cycles", n, 19);
    check("timeout_cause", int'(trap_cause), 2);
    check("timeout_no_regwrite", n_rw - w0, 0);
    check("timeout_trap_pulses", n_it - i0, 1);
    i0 = n_it;
    run(LW, TO - 1, n);
    check("lw_late_ready_cycles", n, 19);
    check("late_ready_no_trap", n_it - i0, 0);
    w0 = n_rw;
    run(32'hFFFFFFFF, 0, n);
    check("illegal_cycles", n, 3);
    check("illegal_cause", int'(trap_cause), 1);
    check("illegal_no_regwrite", n_rw - w0, 0);
    run(BEQ, 0, n);
    check("beq_cycles", n, 3);
    i0 = n_it;
    n0 = n_cyc;
    ion = n0 + 4;
    ioff = n0 + 5;
    run(LW, 2, n);
    check("lw_then_intr_cycles", n, 8);
    check("intr_cause", int'(trap_cause), 0);
    check("intr_one_trap", n_it - i0, 1);
    i0 = n_it;
    ion = n_cyc + 1;
    ioff = NEVER;
    run(ADDI, 0, n);
    check("held_intr_first", n, 4);
    run(ADDI, 0, n);
    check("held_intr_second", n, 3);
    run(ADDI, 0, n);
    ioff = n_cyc;
    check("held_intr_single_trap", n_it - i0, 1);
    i0 = n_it;
    n0 = n_cyc;
    ion = n0 + 1;
    ioff = n0 + 2;
    ion2 = n0 + 3;
    ioff2 = n0 + 4;
    run(ADDI, 0, n);
    check("edge_in_trap_first", n, 4);
    run(ADDI, 0, n);
    check("edge_in_trap_second", n, 4);
    run(ADDI, 0, n);
    check("edge_in_trap_after", n, 3);
    check("edge_in_trap_pulses", n_it - i0, 2);
    ion = NEVER;
    ioff = NEVER;
    ion2 = NEVER;
    ioff2 = NEVER;
    ir = ADD;
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0);
    cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("midexec_reset_state", int'(state), 0);
    check("midexec_reset_regwrite", int'(reg_write), 0);
    check("midexec_reset_pcwrite", int'(pc_write), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_pend = 1'b0;
    iprev = 1'b0;
    m_cause = 2'd0;
    run(ADDI, 0, n);
    check("post_reset_addi_cycles", n, 3);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
